// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with byte FIFO and line-status register behind an MMIO read handshake.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 with a sticky parity error.
`timescale 1ns/1ps
module uart_rx_ctrl #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rxd,
  input  logic        sel,
  input  logic        ren,
  input  logic [31:0] raddr,
  output logic        arready,
  output logic        rvalid,
  output logic [31:0] rdata,
  input  logic        rready,
  output logic        irq
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_C  = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_C  = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_t;

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          rx_m, rx_s;
  logic          push_req, fe_set;
  logic [7:0]    push_data;
  logic          pe;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rxd;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad, pe_set;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      push_req  <= 1'b0;
      push_data <= '0;
      fe_set    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      pe_set    <= 1'b0;
`endif
    end else begin
      push_req <= 1'b0;
      fe_set   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_set   <= 1'b0;
`endif
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          cnt   <= '0;
        end
        START: if (cnt == HALF_C) begin
          // a line that is high again at mid start bit was a glitch
          cnt   <= '0;
          idx   <= '0;
          state <= rx_s ? IDLE : DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == FULL_C) begin
          cnt        <= '0;
          shreg[idx] <= rx_s;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end else idx <= idx + 1'b1;
        end else cnt <= cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
        PARITY: if (cnt == FULL_C) begin
          cnt     <= '0;
          par_bad <= ^{shreg, rx_s};
          state   <= STOP;
        end else cnt <= cnt + 1'b1;
`endif
        STOP: if (cnt == FULL_C) begin
          cnt       <= '0;
          state     <= IDLE;
          push_data <= shreg;
          fe_set    <= !rx_s;
`ifdef UART_RX_PARITY_EN
          pe_set    <= par_bad;
          push_req  <= rx_s && !par_bad;
`else
          push_req  <= rx_s;
`endif
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, accept, is_rbr, is_lsr, pop, do_push, overflow;
  logic          oe, fe;
  logic [7:0]    reg_byte;
  logic [31:0]   rd_word;
  logic          unused_raddr;

  assign unused_raddr = ^raddr[31:3];

  always_comb begin
    empty    = (count == '0);
    full     = (count == DEPTH_C);
    accept   = sel && ren && arready;
    is_rbr   = (raddr[2:0] == 3'd0);
    is_lsr   = (raddr[2:0] == 3'd5);
    pop      = accept && is_rbr && !empty;
    do_push  = push_req && (!full || pop);
    overflow = push_req && full && !pop;
    reg_byte = 8'h00;
    if (is_rbr && !empty) reg_byte = mem[rd_ptr];
    if (is_lsr)           reg_byte = {2'b00, 1'b1, 1'b0, fe, pe, oe, !empty};
    rd_word  = {24'h0, reg_byte} << {raddr[1:0], 3'b000};
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      oe      <= 1'b0;
      fe      <= 1'b0;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      irq     <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // a new error arriving in the same cycle as an LSR read stays visible
      if (accept && is_lsr) begin
        oe <= 1'b0;
        fe <= 1'b0;
      end
      if (overflow) oe <= 1'b1;
      if (fe_set)   fe <= 1'b1;
      if (accept) begin
        arready <= 1'b0;
        rvalid  <= 1'b1;
        rdata   <= rd_word;
      end else if (rvalid && rready) begin
        rvalid  <= 1'b0;
        arready <= 1'b1;
      end
      irq <= !empty;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pe <= 1'b0;
    else begin
      if (accept && is_lsr) pe <= 1'b0;
      if (pe_set)           pe <= 1'b1;
    end
  end
`else
  assign pe = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: bit-banged frames against a queue-based receiver model.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 8;

  logic        clock = 1'b0;
  logic        reset, rxd, sel, ren, rready;
  logic [31:0] raddr;
  logic        arready, rvalid, irq;
  logic [31:0] rdata;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] q[$];
  bit oe_m = 0;
  bit fe_m = 0;

  uart_rx_ctrl #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .rxd(rxd), .sel(sel), .ren(ren), .raddr(raddr),
    .arready(arready), .rvalid(rvalid), .rdata(rdata), .rready(rready), .irq(irq)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic model_push(input logic [7:0] b, input bit stop);
    if (!stop) fe_m = 1;
    else if (q.size() >= DEPTH) oe_m = 1;
    else q.push_back(b);
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] exp);
    int v;
    v = 0;
    if (addr[2:0] == 3'd0) begin
      if (q.size() > 0) v = int'(q.pop_front());
    end else if (addr[2:0] == 3'd5) begin
      v = 32 + 8 * int'(fe_m) + 2 * int'(oe_m) + ((q.size() != 0) ? 1 : 0);
      oe_m = 0;
      fe_m = 0;
    end
    exp = 32'(v) * (32'd1 << (8 * int'(addr[1:0])));
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
`ifdef UART_RX_PARITY_EN
    logic [10:0] bits;
    bits = {stop, ^b, b, 1'b0};
`else
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
`endif
    for (int i = 0; i < $bits(bits); i++) begin
      rxd = bits[i];
      tick(CLK_DIV);
    end
    rxd = 1'b1;
    if (!stop) tick(CLK_DIV);
  endtask

  task automatic bus_read(input logic [31:0] addr, input int hold, output logic [31:0] data);
    int guard;
    guard = 0;
    while (!arready && guard < 50) begin
      tick(1);
      guard++;
    end
    check("arready_before_req", arready, 1);
    sel = 1; ren = 1; raddr = addr;
    tick(1);
    sel = 0; ren = 0;
    check("rvalid_latency", rvalid, 1);
    check("arready_busy", arready, 0);
    data = rdata;
    for (int i = 0; i < hold; i++) begin
      tick(1);
      check("rvalid_hold", rvalid, 1);
      check("rdata_hold", rdata, data);
    end
    rready = 1;
    tick(1);
    rready = 0;
    check("rvalid_cleared", rvalid, 0);
    check("arready_back", arready, 1);
  endtask

  task automatic read_and_check(input string tag, input logic [31:0] addr, input int hold);
    logic [31:0] d, e;
    bus_read(addr, hold, d);
    model_read(addr, e);
    check(tag, d, e);
  endtask

  initial begin
    logic [31:0] addr;
    logic [7:0]  b;
    logic [2:0]  off;
    bit          stop;
    int          nb, nr, guard;

    rxd = 1; sel = 0; ren = 0; rready = 0; raddr = '0; reset = 1;
    tick(3);
    check("rst_arready", arready, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_irq", irq, 0);
    reset = 0;
    tick(4);

    // first frame: irq must be up within 161 cycles of the start edge
    send_frame(8'h55, 1);
    model_push(8'h55, 1);
    tick(1);
    check("irq_after_0x55", irq, 1);
    read_and_check("lsr_after_0x55", 32'h5, 0);
    read_and_check("rbr_0x55", 32'h0, 0);

    send_frame(8'hA3, 1);
    model_push(8'hA3, 1);
    tick(2);
    read_and_check("rbr_0xa3_held", 32'h0, 3);
    check("irq_after_drain", irq, 0);
    read_and_check("lsr_dr_clear", 32'h5, 0);

    // ren without sel must not pop or respond
    send_frame(8'h5A, 1);
    model_push(8'h5A, 1);
    ren = 1; raddr = 32'h0;
    tick(3);
    ren = 0;
    check("nosel_arready", arready, 1);
    check("nosel_rvalid", rvalid, 0);
    read_and_check("rbr_after_nosel", 32'h0, 0);

    // overflow: nine bytes into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1);
      model_push(8'(i), 1);
    end
    tick(2);
    for (int i = 0; i < 8; i++) read_and_check("rbr_overflow_seq", 32'h0, 0);
    read_and_check("lsr_oe_set", 32'h5, 0);
    read_and_check("lsr_oe_cleared", 32'h5, 0);

    // quarter-bit glitch is a false start
    rxd = 0;
    tick(4);
    rxd = 1;
    tick(3 * CLK_DIV);
    check("glitch_irq", irq, 0);
    read_and_check("glitch_lsr", 32'h5, 0);

    // framing error then a good frame
    send_frame(8'hC3, 0);
    model_push(8'hC3, 0);
    tick(4);
    check("fe_no_push_irq", irq, 0);
    read_and_check("lsr_fe", 32'h5, 0);
    send_frame(8'h7E, 1);
    model_push(8'h7E, 1);
    tick(2);
    read_and_check("rbr_0x7e", 32'h0, 0);

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      nb = $urandom_range(1, 10);
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom());
        stop = ($urandom_range(0, 7) != 0);
        send_frame(b, stop);
        model_push(b, stop);
      end
      tick(2);
      check("rand_irq", irq, (q.size() != 0) ? 1 : 0);
      nr = $urandom_range(0, 10);
      for (int i = 0; i < nr; i++) begin
        case ($urandom_range(0, 3))
          0, 1: off = 3'd0;
          2: off = 3'd5;
          default: begin
            off = 3'($urandom_range(1, 6));
            if (off >= 3'd5) off = off + 3'd1;
          end
        endcase
        addr = ($urandom() & 32'hFFFF_FFF8) | 32'(off);
        read_and_check("rand_read", addr, $urandom_range(0, 2));
      end
      read_and_check("rand_lsr", 32'h5, 0);
      guard = 0;
      while (q.size() > 0 && guard < 16) begin
        read_and_check("rand_drain", 32'h0, 0);
        guard++;
      end
    end

    // reset mid-frame with a read pending
    sel = 1; ren = 1; raddr = 32'h5;
    tick(1);
    sel = 0; ren = 0;
    check("pending_rvalid", rvalid, 1);
    rxd = 0;
    tick(CLK_DIV);
    rxd = 1;
    tick(3 * CLK_DIV);
    #3 reset = 1;
    #1;
    check("async_rst_arready", arready, 1);
    check("async_rst_rvalid", rvalid, 0);
    check("async_rst_rdata", rdata, 0);
    q.delete();
    oe_m = 0;
    fe_m = 0;
    tick(2);
    reset = 0;
    tick(12 * CLK_DIV);
    check("partial_dropped_irq", irq, 0);
    send_frame(8'h3C, 1);
    model_push(8'h3C, 1);
    tick(2);
    read_and_check("rbr_0x3c", 32'h0, 0);
    read_and_check("lsr_after_reset", 32'h5, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Serial UART receiver for the SoC MMIO map: the receive-side counterpart of the write-only UART transmit device on the crossbar.
- Deserialises 8N1 frames on `rxd` into a byte FIFO.
- Exposes the received bytes and a line-status register to the crossbar through the same arready/rvalid read handshake the other MMIO slaves use.
- Sits behind the crossbar decode; asserts `irq` while data is available.

Parameters:
CLK_DIV, 16, clock cycles per serial bit (>=4, even)
FIFO_DEPTH, 8, receive FIFO entries (power of 2, >=2)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous reset, active-high
rxd  input  1  serial receive line, idle high, asynchronous to clock
sel  input  1  crossbar decode hit for this device
ren  input  1  read address valid
raddr  input  32  read byte address; [2:0] selects register
arready  output  1  read address accepted
rvalid  output  1  read data valid
rdata  output  32  read data, byte placed at lane raddr[1:0]
rready  input  1  requester accepts rdata
irq  output  1  high while FIFO not empty

Behaviour:
- Reset: one clock, reset asynchronous active-high; all state clears immediately.
  - Reset values: arready=1, rvalid=0, rdata=0, irq=0.
  - RX FSM goes to IDLE, FIFO empty, sticky flags cleared.
  - Reset mid-frame drops the partial byte.
- Synchroniser: rxd passes through 2 flops (reset value 1) before any use; the synchronised line is rx_s.
- RX FSM, with baud counter cnt:
  - IDLE: on rx_s=0, go to START with cnt=0.
  - START: at cnt=CLK_DIV/2-1, sample rx_s.
    - 0: go to DATA, cnt=0, bit index=0.
    - 1 (glitch/false start): return to IDLE.
  - DATA: at cnt=CLK_DIV-1, sample rx_s into bit[index], LSB first; after index 7, go to STOP.
  - STOP: at cnt=CLK_DIV-1, sample rx_s.
    - 1: push the byte.
    - 0: set sticky framing error FE, discard the byte.
    - Either way, return to IDLE.
  - Sampling point is mid-bit. Back-to-back frames with a 1-bit stop are supported.
- FIFO:
  - Push when the frame completes. Push while full drops the byte and sets sticky OE.
  - Push and pop in the same cycle while full: both succeed, OE not set.
- Register map, on raddr[2:0]:
  - 0x0 RBR: pops the FIFO head; returns 0x00 and does not pop if empty.
  - 0x5 LSR: bit0=DR (not empty), bit1=OE, bit2=PE, bit3=FE, bit5=1 (THRE, for compatibility). Reading LSR clears OE/PE/FE.
  - Any other offset: returns 0.
- Read handshake (single outstanding):
  - Accept: when sel&ren&arready, capture the register value, perform the pop/clear side-effect in that same cycle, drive arready=0, and drive rvalid=1 with rdata on the next edge.
  - Hold: rvalid and rdata stay stable until rready. On the rvalid&rready edge: rvalid=0, arready=1.
  - Latency: 1 cycle from accept to rvalid.
  - ren without sel: ignored.
  - Writes: not decoded here; this block has no write port.
- rdata placement: the byte is shifted left by raddr[1:0]*8; all other bits are 0.
- irq: registered, equal to DR.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Frame becomes 8E1: after bit 7 the FSM enters PARITY and samples one more bit at cnt=CLK_DIV-1.
  - Even-parity mismatch sets sticky PE and the byte is discarded even if the stop bit is good.
- Undefined: no PARITY state; LSR bit2 reads 0; pure 8N1.

Test Plan:
- Reset release:
  - Send 0x55 at CLK_DIV=16 with no bus activity -> irq=1 within 160+1 cycles of the start edge.
  - LSR read -> rdata=0x21 at lane 1 (raddr=0x5 => 0x00002100).
- Read RBR after receiving 0xA3 -> rvalid 1 cycle after accept, rdata=0x000000A3.
  - Hold rready=0 for 3 cycles -> rvalid/rdata stable.
  - After the handshake: irq=0, DR=0.
- Receive 9 bytes 0x01..0x09 with FIFO_DEPTH=8 -> 8 RBR reads return 0x01..0x08.
  - Next LSR read returns OE=1 (bit1); a second LSR read returns OE=0.
- 0.25-bit low glitch on rxd (4 cycles) -> FSM returns to IDLE, FIFO unchanged, irq stays 0.
- Frame with stop bit 0 -> no push; LSR bit3 FE=1.
  - Next valid frame 0x7E -> RBR=0x7E.
- Assert reset mid-DATA of frame 0xFF, then send 0x3C -> only 0x3C is in the FIFO.
  - Reset assertion drives arready=1, rvalid=0 without waiting for a clock edge.
